// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Read data returned on an aborted transaction; sliced to DATA_W by users.
    localparam logic [255:0] TIMEOUT_DATA = '1;

    // Winner selection. A lone requester always wins; on contention either
    // data wins outright or the previous owner yields (round-robin).
    function automatic logic pick_owner(input logic i_req, input logic d_req,
                                        input logic last_owner, input logic rr_en);
        if (i_req && d_req) begin
            return rr_en ? ~last_owner : OWNER_D;
        end
        return d_req ? OWNER_D : OWNER_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the arbiter.
// slave = arbiter view, master = pipeline/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              stall_if;
    logic              stall_mem;
    logic              err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr,
               mem_wdata, stall_if, stall_mem, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr,
               mem_wdata, stall_if, stall_mem, err
    );
endinterface

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: saturating wait counter for a pending memory transaction.
// expire is high once the count has reached TIMEOUT-1.
module mem_arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int             CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch stage
// and the MEM stage, sequences each transaction and returns read data.
// Build macro MEM_PORT_ARBITER_RR_EN: round-robin on contention; when
// undefined, data requests always beat fetch requests.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
`ifdef MEM_PORT_ARBITER_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif
    localparam logic [DATA_W-1:0] FILL = TIMEOUT_DATA[DATA_W-1:0];

    arb_state_e        state_q,     state_d;
    logic              owner_q,     owner_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              i_ready_q,   i_ready_d;
    logic              d_ready_q,   d_ready_d;
    logic              err_q,       err_d;
    logic              grant;
    logic              timer_clear;
    logic              timer_en;
    logic              timer_expire;

    // The wait timer only runs while a transaction is outstanding.
    assign timer_en    = (state_q == BUSY);
    assign timer_clear = (state_q != BUSY);

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (timer_expire)
    );

    // Next-state logic: grant in IDLE, wait for ack or timeout in BUSY,
    // one-cycle ready pulse in DONE.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = err_q;
        grant       = OWNER_D;
        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    grant     = pick_owner(bus.i_req, bus.d_req, owner_q, RR_EN);
                    owner_d   = grant;
                    mem_req_d = 1'b1;
                    state_d   = BUSY;
                    if (grant == OWNER_D) begin
                        mem_addr_d  = bus.d_addr;
                        mem_we_d    = bus.d_we;
                        mem_wdata_d = bus.d_wdata;
                    end else begin
                        mem_addr_d  = bus.i_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (owner_q == OWNER_I) begin
                        i_rdata_d = bus.mem_rdata;
                        i_ready_d = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                        d_ready_d = 1'b1;
                    end
                end else if (timer_expire) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = DONE;
                    if (owner_q == OWNER_I) begin
                        i_rdata_d = FILL;
                        i_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = FILL;
                        d_ready_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_D;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.err       = err_q;
    assign bus.stall_if  = bus.i_req & ~i_ready_q;
    assign bus.stall_mem = bus.d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
`ifdef MEM_PORT_ARBITER_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mem_exp_t;

    mem_exp_t    mem_q[$];
    logic [31:0] iq[$];
    logic [31:0] dq[$];

    int checks = 0;
    int errors = 0;
    int i_pulses = 0, d_pulses = 0, n_i_exp = 0, n_d_exp = 0;
    int busy_cnt = 0, last_busy = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    logic inject_ack = 1'b0;
    logic [31:0] d_model = '0;
    logic last_owner_m = OWNER_D;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h8C01_0004;
            32'h200: return 32'h55AA_55AA;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Memory responder: acks ack_delay cycles into BUSY; -1 means never.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clock);
            #1;
            bus.mem_ack = 1'b0;
            if (bus.mem_req === 1'b1) begin
                if (ack_delay >= 0 && wait_cnt == ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_f(bus.mem_addr);
                end
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                if (inject_ack) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = 32'hDEAD_BEEF;
                end
            end
        end
    end

    // Output monitor: memory issue order, ready pulses and returned data.
    initial begin : mon
        mem_exp_t e;
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.mem_req === 1'b1 && !prev_req) begin
                if (mem_q.size() == 0) begin
                    check_eq("mem_req_spurious", bus.mem_req, 1'b0);
                end else begin
                    e = mem_q.pop_front();
                    check_eq("mem_addr", bus.mem_addr, e.addr);
                    check_eq("mem_we", bus.mem_we, e.we);
                    if (e.we) check_eq("mem_wdata", bus.mem_wdata, e.wdata);
                end
            end
            if (bus.mem_req === 1'b1) begin
                busy_cnt++;
            end else if (prev_req) begin
                last_busy = busy_cnt;
                busy_cnt  = 0;
            end
            prev_req = (bus.mem_req === 1'b1);
            if (bus.i_ready === 1'b1) begin
                i_pulses++;
                if (iq.size() == 0) check_eq("i_ready_spurious", bus.i_ready, 1'b0);
                else check_eq("i_rdata", bus.i_rdata, iq.pop_front());
            end
            if (bus.d_ready === 1'b1) begin
                d_pulses++;
                if (dq.size() == 0) check_eq("d_ready_spurious", bus.d_ready, 1'b0);
                else check_eq("d_rdata", bus.d_rdata, dq.pop_front());
            end
        end
    end

    // Predict memory issue order for nd data and ni fetch transactions
    // whose requests are all present together and held back to back.
    task automatic plan(input int nd, input int ni, input logic dwe,
                        input logic [31:0] dbase, input logic [31:0] dwbase,
                        input logic [31:0] ibase);
        int jd = 0;
        int ji = 0;
        logic g;
        mem_exp_t e;
        while (jd < nd || ji < ni) begin
            if (jd < nd && ji < ni) g = RR_MODE ? ~last_owner_m : OWNER_D;
            else g = (jd < nd) ? OWNER_D : OWNER_I;
            if (g == OWNER_D) begin
                e.addr = dbase + 32'(4 * jd); e.we = dwe; e.wdata = dwbase + 32'(jd);
                jd++;
            end else begin
                e.addr = ibase + 32'(4 * ji); e.we = 1'b0; e.wdata = '0;
                ji++;
            end
            mem_q.push_back(e);
            last_owner_m = g;
        end
    endtask

    // Requester: n back-to-back transactions, req held until each ready.
    task automatic run_port(input bit is_d, input int n, input logic we,
                            input logic [31:0] base, input logic [31:0] wbase,
                            output int stalls);
        logic [31:0] a;
        logic [31:0] rd;
        bit got;
        stalls = 0;
        for (int j = 0; j < n; j++) begin
            a = base + 32'(4 * j);
            if (ack_delay < 0) rd = '1;
            else if (is_d && we) rd = d_model;
            else rd = mem_f(a);
            if (is_d) begin
                d_model = rd;
                bus.d_we = we; bus.d_addr = a; bus.d_wdata = wbase + 32'(j);
                bus.d_req = 1'b1;
                dq.push_back(rd);
                n_d_exp++;
            end else begin
                bus.i_addr = a;
                bus.i_req = 1'b1;
                iq.push_back(rd);
                n_i_exp++;
            end
            got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clock);
                if (is_d) begin
                    if (bus.d_ready === 1'b1) got = 1'b1;
                    else if (bus.stall_mem === 1'b1) stalls++;
                end else begin
                    if (bus.i_ready === 1'b1) got = 1'b1;
                    else if (bus.stall_if === 1'b1) stalls++;
                end
            end
            if (is_d) begin
                if (!got) check_eq("d_ready_wait", bus.d_ready, 1'b1);
                else check_eq("stall_mem_at_ready", bus.stall_mem, 1'b0);
            end else begin
                if (!got) check_eq("i_ready_wait", bus.i_ready, 1'b1);
                else check_eq("stall_if_at_ready", bus.stall_if, 1'b0);
            end
        end
        if (is_d) bus.d_req = 1'b0;
        else bus.i_req = 1'b0;
    endtask

    task automatic reset_model();
        d_model      = '0;
        last_owner_m = OWNER_D;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int st, st2;
        int ip0, dp0;
        mem_exp_t e;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset state.
        #2 reset = 1'b1;
        #1;
        check_eq("rst_mem_req", bus.mem_req, 1'b0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
        check_eq("rst_ready", {bus.i_ready, bus.d_ready}, 2'b00);
        check_eq("rst_err", bus.err, 1'b0);
        check_eq("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
        check_eq("rst_stall", {bus.stall_if, bus.stall_mem}, 2'b00);
        reset_model();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Fetch only, ack one cycle after mem_req.
        @(posedge clock); #1;
        ack_delay = 1;
        plan(0, 1, 1'b0, 32'h0, 32'h0, 32'h40);
        run_port(1'b0, 1, 1'b0, 32'h40, 32'h0, st);
        check_eq("fetch_stall_cycles", st, 3);
        check_eq("fetch_err", bus.err, 1'b0);

        // Load with five wait cycles.
        @(posedge clock); #1;
        ack_delay = 5;
        plan(1, 0, 1'b0, 32'h200, 32'h0, 32'h0);
        run_port(1'b1, 1, 1'b0, 32'h200, 32'h0, st);
        check_eq("load_stall_cycles", st, 7);
        @(negedge clock);
        check_eq("load_stall_after", bus.stall_mem, 1'b0);

        // Simultaneous store and fetch.
        @(posedge clock); #1;
        ack_delay = 0;
        ip0 = i_pulses; dp0 = d_pulses;
        plan(1, 1, 1'b1, 32'h100, 32'h1234, 32'h44);
        fork
            run_port(1'b1, 1, 1'b1, 32'h100, 32'h1234, st);
            run_port(1'b0, 1, 1'b0, 32'h44, 32'h0, st2);
        join
        repeat (3) @(negedge clock);
        check_eq("both_i_pulses", i_pulses - ip0, 1);
        check_eq("both_d_pulses", d_pulses - dp0, 1);

        // Both requesters streaming two transactions each.
        @(posedge clock); #1;
        ip0 = i_pulses; dp0 = d_pulses;
        plan(2, 2, 1'b0, 32'h300, 32'h0, 32'h80);
        fork
            run_port(1'b1, 2, 1'b0, 32'h300, 32'h0, st);
            run_port(1'b0, 2, 1'b0, 32'h80, 32'h0, st2);
        join
        repeat (3) @(negedge clock);
        check_eq("stream_i_pulses", i_pulses - ip0, 2);
        check_eq("stream_d_pulses", d_pulses - dp0, 2);

        // Memory never acks: timeout abort.
        @(posedge clock); #1;
        ack_delay = -1;
        plan(0, 1, 1'b0, 32'h0, 32'h0, 32'h48);
        run_port(1'b0, 1, 1'b0, 32'h48, 32'h0, st);
        check_eq("timeout_stall_cycles", st, 17);
        @(negedge clock);
        check_eq("timeout_busy_cycles", last_busy, 16);
        check_eq("timeout_err", bus.err, 1'b1);

        // err is sticky across a later good transaction.
        @(posedge clock); #1;
        ack_delay = 0;
        plan(0, 1, 1'b0, 32'h0, 32'h0, 32'h4C);
        run_port(1'b0, 1, 1'b0, 32'h4C, 32'h0, st);
        check_eq("err_sticky", bus.err, 1'b1);

        // Reset in the middle of a load.
        @(posedge clock); #1;
        ack_delay = 10;
        dp0 = d_pulses;
        e.addr = 32'h204; e.we = 1'b0; e.wdata = '0;
        mem_q.push_back(e);
        bus.d_we = 1'b0; bus.d_addr = 32'h204; bus.d_req = 1'b1;
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_mem_req", bus.mem_req, 1'b0);
        check_eq("midrst_ready", {bus.i_ready, bus.d_ready}, 2'b00);
        check_eq("midrst_err", bus.err, 1'b0);
        check_eq("midrst_d_rdata", bus.d_rdata, 32'h0);
        bus.d_req = 1'b0;
        reset_model();
        ack_delay = -1;
        @(negedge clock);
        reset = 1'b0;
        inject_ack = 1'b1;
        @(negedge clock);
        @(negedge clock);
        inject_ack = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("late_ack_mem_req", bus.mem_req, 1'b0);
        check_eq("late_ack_no_ready", d_pulses - dp0, 0);

        // Recovery after reset.
        @(posedge clock); #1;
        ack_delay = 0;
        plan(0, 1, 1'b0, 32'h0, 32'h0, 32'h50);
        run_port(1'b0, 1, 1'b0, 32'h50, 32'h0, st);
        check_eq("recover_stall_cycles", st, 2);
        check_eq("recover_err", bus.err, 1'b0);

        repeat (3) @(negedge clock);
        check_eq("i_pulses_total", i_pulses, n_i_exp);
        check_eq("d_pulses_total", d_pulses, n_d_exp);
        check_eq("mem_q_left", mem_q.size(), 0);
        check_eq("iq_left", iq.size(), 0);
        check_eq("dq_left", dq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch stage and the MEM stage of the 5-stage pipeline.
- Arbitrates between the two, sequences each multi-cycle memory transaction and returns read data.
- Generates stall signals for the pipeline registers so that IF/ID and EXE/MEM hold while their access is pending.
- Includes a transaction timeout with a sticky error flag.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width.
- TIMEOUT, 16, maximum cycles in BUSY waiting for mem_ack before abort (≥2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held until i_ready.
- i_addr  in  ADDR_W  fetch address; stable while i_req.
- i_rdata  out  DATA_W  fetched instruction; valid with i_ready.
- i_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store (sw), 0 = load (lw).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid with d_ready.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle memory completion.
- stall_if  out  1  i_req & ~i_ready (combinational).
- stall_mem  out  1  d_req & ~d_ready (combinational).
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; mem_req, mem_we, i_ready, d_ready, err = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0; timer = 0; owner = D. Reset mid-transaction abandons it; no ready pulse is issued.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise select the winner (default: d_req beats i_req).
  - Register owner, mem_addr, mem_we (d_we, or 0 for fetch) and mem_wdata.
  - Set mem_req=1 and go to BUSY.
- BUSY:
  - mem_req and all mem_* outputs are held stable.
  - timer increments each cycle.
  - On mem_ack: capture mem_rdata into the owner's rdata register (loads/fetches only; stores leave d_rdata unchanged), drop mem_req, go to DONE.
  - If timer reaches TIMEOUT-1 without ack: drop mem_req, set owner rdata to all-ones, set err=1, go to DONE.
- DONE:
  - Assert the owner's ready for exactly one cycle, then go to IDLE. timer clears.
- Latency: request sampled in IDLE at edge N; mem_req visible from cycle N+1. With mem_ack in cycle N+1+k, ready is high in cycle N+2+k. Minimum 3 cycles from request to ready.
- Requests are re-sampled only in IDLE. A req still high in the DONE cycle is not re-granted until IDLE.
- A mem_ack arriving outside BUSY is ignored.
- err is cleared only by reset.

Optional Feature:
- Macro: MEM_PORT_ARBITER_RR_EN.
- Defined: round-robin arbitration. When both requests are present in IDLE, grant the requester that did not own the previous transaction. A single requester is always granted.
- Undefined: fixed priority, data over fetch.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, BUSY, DONE}
  - owner constants OWNER_I=0, OWNER_D=1
  - the all-ones timeout data constant
- One natural sub-module: mem_arb_timer. It is a saturating TIMEOUT counter with clear/enable inputs and an expire output, reset asynchronously.

Test Plan:
- Fetch only, i_addr=0x40, memory acks 1 cycle after mem_req with 0x8C010004 -> mem_addr=0x40, mem_we=0, i_ready pulses once 3 cycles after i_req, i_rdata=0x8C010004, stall_if high until then.
- Simultaneous i_req (0x44) and d_req store (0x100, 0x1234), fixed priority -> store issued first (mem_we=1, mem_wdata=0x1234), d_ready pulses, then fetch issues, i_ready pulses; each ready pulses exactly once.
- With MEM_PORT_ARBITER_RR_EN, both requests held continuously for 4 transactions -> owners alternate D, I, D, I.
- Memory never acks, TIMEOUT=16 -> mem_req drops after 16 BUSY cycles, owner rdata=0xFFFFFFFF, ready pulses, err=1 and stays 1.
- Reset asserted mid-BUSY -> mem_req, ready outputs and err go 0 asynchronously; a late mem_ack after reset release is ignored with no ready pulse.
- Load d_addr=0x200, ack with 0x55AA55AA after 5 wait cycles -> d_rdata=0x55AA55AA, stall_mem high for 7 cycles, then low.
